// File: rtl/xpmwrap_fifo_wr_arb.sv
// Round-robin arbiter sharing one xpmwrap_fifo_sync write port among NUM_REQ valid/ready requesters.
// Define XPMWRAP_FIFO_WR_ARB_PKT_LOCK_EN to hold each grant until the req_last beat (packet lock).
module xpmwrap_fifo_wr_arb #(
  parameter int NUM_REQ          = 4,
  parameter int WRITE_DATA_WIDTH = 32,
  localparam int IW              = $clog2(NUM_REQ)
) (
  input  logic                                wr_clk,
  input  logic                                rst_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ*WRITE_DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]                  req_last,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic [WRITE_DATA_WIDTH-1:0]         din,
  output logic                                wr_en,
  input  logic                                full,
  input  logic                                wr_rst_busy,
  output logic                                grant_valid,
  output logic [IW-1:0]                       grant_id,
  output logic                                pkt_done
);

  typedef enum logic [1:0] {
    S_HOLD  = 2'd0,
    S_IDLE  = 2'd1,
    S_BURST = 2'd2
  } state_t;

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   winner;
  logic [IW-1:0]   rr_next;
  logic            found;
  logic            in_burst;
  logic            wr_last;
  logic            release_beat;
  int unsigned     pos;

  // Circular priority search starting at rr_ptr.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    pos    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = 32'(rr_ptr) + k;
      if (pos >= 32'(NUM_REQ)) pos = pos - 32'(NUM_REQ);
      if (!found && req_valid[pos]) begin
        found  = 1'b1;
        winner = pos[IW-1:0];
      end
    end
  end

  assign in_burst = (state == S_BURST);

  always_comb begin
    req_ready = '0;
    din       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (in_burst && (grant_id == IW'(i))) begin
        req_ready[i] = !full && !wr_rst_busy;
        din          = req_data[i*WRITE_DATA_WIDTH +: WRITE_DATA_WIDTH];
      end
    end
  end

  // At most one ready bit is set, so the OR-reduction selects the grantee.
  assign wr_en   = |(req_valid & req_ready);
  assign wr_last = |(req_valid & req_ready & req_last);

`ifdef XPMWRAP_FIFO_WR_ARB_PKT_LOCK_EN
  assign release_beat = wr_last;
`else
  assign release_beat = wr_en;
`endif

  assign rr_next = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + IW'(1);

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_HOLD;
      rr_ptr      <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      pkt_done    <= 1'b0;
    end else begin
      pkt_done <= wr_last;
      if (wr_rst_busy) begin
        state       <= S_HOLD;
        grant_valid <= 1'b0;
      end else begin
        case (state)
          S_HOLD: state <= S_IDLE;
          S_IDLE: begin
            if (found) begin
              state       <= S_BURST;
              grant_id    <= winner;
              grant_valid <= 1'b1;
            end
          end
          S_BURST: begin
            if (release_beat) begin
              state       <= S_IDLE;
              grant_valid <= 1'b0;
              rr_ptr      <= rr_next;
            end
          end
          default: begin
            state       <= S_HOLD;
            grant_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_xpmwrap_fifo_wr_arb.sv
// Self-checking bench for xpmwrap_fifo_wr_arb: per-cycle reference model plus directed scenarios.
module tb_xpmwrap_fifo_wr_arb;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int IW = 2;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  logic            wr_clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*W-1:0]  req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic [W-1:0]    din;
  logic            wr_en;
  logic            full;
  logic            wr_rst_busy;
  logic            grant_valid;
  logic [IW-1:0]   grant_id;
  logic            pkt_done;

  xpmwrap_fifo_wr_arb #(.NUM_REQ(N), .WRITE_DATA_WIDTH(W)) dut (
    .wr_clk(wr_clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .din(din), .wr_en(wr_en),
    .full(full), .wr_rst_busy(wr_rst_busy), .grant_valid(grant_valid),
    .grant_id(grant_id), .pkt_done(pkt_done)
  );

  always #5 wr_clk = ~wr_clk;

  // Requester sources and knobs applied one tick after each rising edge.
  beat_t        q[N][$];
  logic [N-1:0] ven;
  logic         full_k, busy_k, rst_knob;

  // Reference model: who owns the port, whether the FIFO has been seen idle since busy.
  int           owner;
  bit           up;
  logic [IW-1:0] gid_m;
  int           rr;
  bit           done_m;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    owner = -1; up = 0; gid_m = '0; rr = 0; done_m = 0;
  endtask

  task automatic model_edge();
    bit wrote, rel;
    int o;
    if (!rst_n) return;
    o     = owner;
    wrote = (o >= 0) && req_valid[o] && !full && !wr_rst_busy;
    done_m = wrote && req_last[o];
`ifdef XPMWRAP_FIFO_WR_ARB_PKT_LOCK_EN
    rel = wrote && req_last[o];
`else
    rel = wrote;
`endif
    if (wrote) void'(q[o].pop_front());
    if (wr_rst_busy) begin
      owner = -1; up = 0;
    end else if (!up) begin
      up = 1;
    end else if (owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (rr + k) % N;
        if (owner < 0 && req_valid[i]) begin
          owner = i; gid_m = IW'(i);
        end
      end
    end else if (rel) begin
      rr = (owner + 1) % N; owner = -1;
    end
  endtask

  task automatic drive();
    rst_n = rst_knob;
    if (!rst_knob) model_reset();
    full = full_k;
    wr_rst_busy = busy_k;
    for (int i = 0; i < N; i++) begin
      if (ven[i] && q[i].size() > 0) begin
        req_valid[i] = 1'b1;
        req_data[i*W +: W] = q[i][0].data;
        req_last[i] = q[i][0].last;
      end else begin
        req_valid[i] = 1'b0;
        req_data[i*W +: W] = $urandom;
        req_last[i] = 1'($urandom);
      end
    end
  endtask

  task automatic model_cmp();
    logic [N-1:0] er;
    logic ew, eg;
    logic [W-1:0] ed;
    er = '0; ew = 1'b0; ed = '0; eg = (owner >= 0);
    if (owner >= 0) begin
      ed = req_data[owner*W +: W];
      er[owner] = !full && !wr_rst_busy;
      ew = req_valid[owner] && er[owner];
    end
    n_checks++;
    if (req_ready !== er || wr_en !== ew || din !== ed || grant_valid !== eg ||
        grant_id !== gid_m || pkt_done !== done_m)
      $display("FAIL model_cmp t=%0t ready=%b/%b wr_en=%b/%b din=%h/%h gv=%b/%b gid=%0d/%0d done=%b/%b (got/want)",
               $time, req_ready, er, wr_en, ew, din, ed, grant_valid, eg, grant_id, gid_m, pkt_done, done_m);
    else n_pass++;
  endtask

  // One clock cycle: model follows the edge, new inputs applied, outputs compared mid-cycle.
  task automatic cycle();
    @(posedge wr_clk);
    model_edge();
    #1;
    drive();
    @(negedge wr_clk);
    model_cmp();
  endtask

  task automatic push(input int i, input logic [W-1:0] d, input logic l);
    beat_t b;
    b.data = d; b.last = l;
    q[i].push_back(b);
  endtask

  task automatic do_reset();
    rst_knob = 1'b0; busy_k = 1'b0; full_k = 1'b0; ven = '0;
    for (int i = 0; i < N; i++) q[i].delete();
    repeat (2) cycle();
    rst_knob = 1'b1;
  endtask

  task automatic wait_write(input int bound, output bit seen);
    seen = 0;
    for (int t = 0; t < bound && !seen; t++) begin
      cycle();
      if (wr_en === 1'b1) seen = 1;
    end
  endtask

  initial begin
    bit seen;
    int k, cnt;
    int ids[$];
    int cyc[$];
    logic [W-1:0] wq[$];
    int done_cyc[$];
    int c_cyc;

    rst_knob = 1'b0; busy_k = 1'b0; full_k = 1'b0; ven = '0;
    model_reset();
    drive();

    // Reset and busy
    rst_knob = 1'b0;
    repeat (3) cycle();
    check("rst_wr_en", {63'd0, wr_en}, 64'd0);
    check("rst_din", {32'd0, din}, 64'd0);
    check("rst_grant_valid", {63'd0, grant_valid}, 64'd0);
    busy_k = 1'b1; ven = 4'b1111; rst_knob = 1'b1;
    for (int i = 0; i < N; i++) push(i, 32'h1000_0000 + i, 1'b1);
    cnt = 0;
    for (int t = 0; t < 5; t++) begin
      cycle();
      cnt += int'(wr_en) + int'(grant_valid);
    end
    check("busy_no_activity", cnt, 0);
    busy_k = 1'b0;
    cycle();
    k = 0;
    while (wr_en !== 1'b1 && k < 20) begin
      cycle();
      k++;
    end
    check("busy_release_latency", k, 2);
    check("busy_release_gid", {62'd0, grant_id}, 64'd0);

    // Fairness with single-beat packets
    do_reset();
    ven = 4'b1111;
    for (int i = 0; i < N; i++)
      for (int s = 0; s < 8; s++) push(i, (i << 16) | s, 1'b1);
    for (int t = 0; t < 40 && ids.size() < 6; t++) begin
      cycle();
      if (wr_en === 1'b1) begin
        ids.push_back(int'(grant_id));
        cyc.push_back(t);
      end
    end
    check("fair_count", ids.size(), 6);
    for (int j = 0; j < 6 && j < ids.size(); j++) check($sformatf("fair_id%0d", j), ids[j], j % N);
    for (int j = 1; j < cyc.size(); j++) check($sformatf("fair_gap%0d", j), cyc[j] - cyc[j-1], 2);

    // Packet: requester 2 sends A,B,C(last) while requester 3 holds D(last)
    do_reset();
    push(2, 32'hAAAA_0001, 1'b0);
    push(2, 32'hBBBB_0002, 1'b0);
    push(2, 32'hCCCC_0003, 1'b1);
    push(3, 32'hDDDD_0004, 1'b1);
    ven = 4'b1100;
    c_cyc = -10;
    for (int t = 0; t < 40; t++) begin
      cycle();
      if (pkt_done === 1'b1) done_cyc.push_back(t);
      if (wr_en === 1'b1) begin
        wq.push_back(din);
        if (din == 32'hCCCC_0003) c_cyc = t;
      end
    end
    check("pkt_count", wq.size(), 4);
    if (wq.size() == 4) begin
`ifdef XPMWRAP_FIFO_WR_ARB_PKT_LOCK_EN
      check("pkt_w0", wq[0], 32'hAAAA_0001);
      check("pkt_w1", wq[1], 32'hBBBB_0002);
      check("pkt_w2", wq[2], 32'hCCCC_0003);
      check("pkt_w3", wq[3], 32'hDDDD_0004);
`else
      check("pkt_w0", wq[0], 32'hAAAA_0001);
      check("pkt_w1", wq[1], 32'hDDDD_0004);
      check("pkt_w2", wq[2], 32'hBBBB_0002);
      check("pkt_w3", wq[3], 32'hCCCC_0003);
`endif
    end
    check("pkt_done_pulses", done_cyc.size(), 2);
    cnt = 0;
    foreach (done_cyc[j]) if (done_cyc[j] == c_cyc + 1) cnt++;
    check("pkt_done_after_c", cnt, 1);

    // Full backpressure mid-packet
    do_reset();
    for (int s = 0; s < 4; s++) push(1, 32'h5100_0000 + s, s == 3);
    ven = 4'b0010;
    wait_write(10, seen);
    check("full_first_write", {63'd0, seen}, 64'd1);
    check("full_first_din", {32'd0, din}, 64'h5100_0000);
    full_k = 1'b1;
    for (int t = 0; t < 3; t++) begin
      cycle();
      check($sformatf("full_stall_wr_en%0d", t), {63'd0, wr_en}, 64'd0);
      check($sformatf("full_stall_ready%0d", t), {60'd0, req_ready}, 64'd0);
    end
    full_k = 1'b0;
    cycle();
    check("full_resume_wr_en", {63'd0, wr_en}, 64'd1);
    check("full_resume_din", {32'd0, din}, 64'h5100_0001);
    wq.delete();
    for (int t = 0; t < 12; t++) begin
      cycle();
      if (wr_en === 1'b1) wq.push_back(din);
    end
    check("full_rest_count", wq.size(), 2);
    if (wq.size() == 2) begin
      check("full_rest0", wq[0], 32'h5100_0002);
      check("full_rest1", wq[1], 32'h5100_0003);
    end

    // Busy while requester 1 holds the grant
    do_reset();
    push(0, 32'h0B00_0000, 1'b1);
    for (int s = 0; s < 3; s++) push(1, 32'h1B00_0000 + s, s == 2);
    ven = 4'b0001;
    wait_write(10, seen);
    check("bmid_r0_write", {63'd0, seen}, 64'd1);
    full_k = 1'b1; ven = 4'b0011;
    seen = 0;
    for (int t = 0; t < 10 && !seen; t++) begin
      cycle();
      if (grant_valid === 1'b1 && grant_id == 2'd1) seen = 1;
    end
    check("bmid_grant1", {63'd0, seen}, 64'd1);
    busy_k = 1'b1; full_k = 1'b0;
    push(0, 32'h0B00_0001, 1'b1);
    cycle();
    check("bmid_gate_wr_en", {63'd0, wr_en}, 64'd0);
    check("bmid_gate_ready", {60'd0, req_ready}, 64'd0);
    cycle();
    check("bmid_grant_dropped", {63'd0, grant_valid}, 64'd0);
    busy_k = 1'b0;
    wait_write(10, seen);
    check("bmid_resume_write", {63'd0, seen}, 64'd1);
    check("bmid_resume_gid", {62'd0, grant_id}, 64'd1);
    check("bmid_resume_din", {32'd0, din}, 64'h1B00_0000);

    // Asynchronous reset between edges mid-packet
    do_reset();
    for (int s = 0; s < 3; s++) push(2, 32'h2C00_0000 + s, s == 2);
    ven = 4'b0100;
    wait_write(10, seen);
    check("arst_pre_write", {63'd0, seen}, 64'd1);
    #2;
    rst_knob = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_wr_en", {63'd0, wr_en}, 64'd0);
    check("arst_ready", {60'd0, req_ready}, 64'd0);
    check("arst_din", {32'd0, din}, 64'd0);
    check("arst_grant_valid", {63'd0, grant_valid}, 64'd0);
    check("arst_grant_id", {62'd0, grant_id}, 64'd0);
    check("arst_pkt_done", {63'd0, pkt_done}, 64'd0);
    cycle();

    // Randomized traffic against the model
    do_reset();
    for (int t = 0; t < 3000; t++) begin
      ven    = N'($urandom);
      full_k = ($urandom % 4) == 0;
      busy_k = ($urandom % 50) == 0;
      for (int i = 0; i < N; i++)
        if (q[i].size() < 5 && ($urandom % 3) == 0)
          push(i, (32'(i) << 24) | 32'(t), ($urandom % 3) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/xpmwrap_fifo_wr_arb.md
# xpmwrap_fifo_wr_arb

Round-robin write-port arbiter that shares one `xpmwrap_fifo_sync` write port among `NUM_REQ` valid/ready requesters. Sits directly in front of the FIFO's `din`/`wr_en`: it selects a requester, forwards its beats, and honours `full` and `wr_rst_busy`. Optionally locks the grant for a whole packet so packets from different requesters never interleave in the FIFO.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `WRITE_DATA_WIDTH`, 32: beat width; must match the FIFO `WRITE_DATA_WIDTH`.
- `IW`, `$clog2(NUM_REQ)`: local parameter, grant index width.
- `wr_clk` in 1: the single clock, shared with the FIFO write side.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: bit i, requester i has a beat.
- `req_data` in NUM_REQ*WRITE_DATA_WIDTH: requester i at slice [i*W +: W].
- `req_last` in NUM_REQ: bit i marks the final beat of a packet.
- `req_ready` out NUM_REQ: bit i, beat i is accepted this cycle when valid.
- `din` out WRITE_DATA_WIDTH: to FIFO `din`.
- `wr_en` out 1: to FIFO `wr_en`.
- `full` in 1: from FIFO `full`.
- `wr_rst_busy` in 1: from FIFO `wr_rst_busy`.
- `grant_valid` out 1: a grant is held (state BURST).
- `grant_id` out IW: index of the current grantee.
- `pkt_done` out 1: one-cycle pulse when a beat with `req_last` is written.

## Operation
- **FSM states**
  - HOLD: reset, or FIFO busy.
  - IDLE: arbitrating.
  - BURST: granted.
- **Transitions**
  - HOLD→IDLE when `wr_rst_busy`=0.
  - Any state→HOLD when `wr_rst_busy`=1. This drops the grant and leaves `rr_ptr` unchanged.
  - IDLE→BURST when any `req_valid` is set. The winner is the first set bit searched circularly from `rr_ptr` upward. The winner is registered into `grant_id`.
  - BURST→IDLE on the release beat (see Configuration). On release, `rr_ptr` ← (`grant_id`+1) mod `NUM_REQ`.
- **Datapath (combinational)**
  - `req_ready[i]` = (state==BURST) & (i==`grant_id`) & !`full` & !`wr_rst_busy`.
  - `wr_en` = `req_valid[grant_id]` & `req_ready[grant_id]`.
  - `din` = `req_data` slice of `grant_id`. This is don't-care while `wr_en`=0, but is driven to 0 outside BURST.
- `wr_en` is never asserted while `full`=1 or `wr_rst_busy`=1. No beat is ever dropped or duplicated.
- If the grantee deasserts `req_valid` mid-grant, the grant is held and no other requester is served.
- `pkt_done` is registered: it is 1 in the cycle after a write with `req_last[grant_id]`=1.
- **Reset values**
  - state = HOLD, `rr_ptr`=0, `grant_id`=0.
  - `grant_valid`=0, `pkt_done`=0.
  - `req_ready`=0, `wr_en`=0, `din`=0.

## Timing
- Arbitration costs one cycle:
  - `req_valid` rises in cycle N with the block in IDLE.
  - The grant is visible in N+1.
  - The first `wr_en` occurs in N+1 if `full`=0.
- Within BURST, throughput is one beat per cycle while valid=1 and `full`=0. `full` gates `wr_en` the same cycle, with zero latency.
- After release, the next arbitration occurs in the following cycle. Each grant therefore costs at least two cycles, and the bubble is unavoidable.
- `wr_rst_busy` asserting in cycle N gates that cycle's `wr_en`. The state is HOLD from N+1.
- `rst_n` asserted mid-burst clears all state immediately (asynchronously). A partially written packet remains in the FIFO; flushing it is the system's responsibility.
- Simultaneous requests are resolved by `rr_ptr` only. A requester's bit asserting while another requester holds the grant waits for that grant's release.

## Configuration
- Macro `XPMWRAP_FIFO_WR_ARB_PKT_LOCK_EN`.
- **Defined:** the release beat is the written beat with `req_last[grant_id]`=1. The grant persists across `full` stalls and valid gaps until that beat, so packets never interleave.
- **Undefined:** the release beat is any written beat. Each grant carries exactly one beat, giving beat-level round-robin. `req_last` only drives `pkt_done`.

## Test plan
- **Reset and busy:** hold `rst_n`=0, then release with `wr_rst_busy`=1 for 5 cycles while `req_valid`=4'b1111.
  - Expect `wr_en`=0 and state HOLD throughout.
  - First `wr_en` occurs 2 cycles after `wr_rst_busy` falls, with `grant_id`=0.
- **Fairness:** all 4 requesters continuously valid with single-beat packets.
  - Expect write order 0,1,2,3,0,1.
  - Exactly one `wr_en` every 2 cycles.
- **Packet lock (macro defined):**
  - Stimulus: requester 2 sends a 3-beat packet (A,B,C with last on C) while requester 3 is valid.
  - Expect FIFO order A,B,C then requester 3's beat.
  - `pkt_done` pulses once, the cycle after C.
- **Full backpressure:**
  - Stimulus: assert `full` for 3 cycles mid-packet.
  - Expect `wr_en`=0 and `req_ready`=0 for those cycles.
  - The data beat presented is written in the first cycle `full`=0, with no loss or duplicate.
- **Busy mid-burst:**
  - Stimulus: raise `wr_rst_busy` during grant to requester 1.
  - Expect `wr_en` low that same cycle and `grant_valid`=0 next cycle.
  - After busy falls, arbitration resumes from `rr_ptr`=1 (grant to requester 1 if valid).
- **Async reset mid-packet:**
  - Stimulus: pulse `rst_n` low between clock edges.
  - Expect all outputs 0 immediately and `grant_valid`=0.
